// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch resolution unit.
//   - branch condition encodings carried on the 3-bit op field
//   - FSM state type for branch_unit
//   - sequential fetch increment used when the branch falls through
// Optional feature macro: BRANCH_UNIT_UNSIGNED_EN (enables BLTU/BGEU).
package branch_unit_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational operand comparator for branch_unit.
// Ports:
//   a, b  : N-bit operands (rs1, rs2)
//   eq    : a == b
//   lt_s  : a < b as two's-complement values
//   lt_u  : a < b as unsigned values (constant 0 unless
//           BRANCH_UNIT_UNSIGNED_EN is defined)
// Optional feature macro: BRANCH_UNIT_UNSIGNED_EN.
module branch_cmp #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq,
  output logic         lt_s,
  output logic         lt_u
);

`ifdef BRANCH_UNIT_UNSIGNED_EN
  // Extra MSB of the zero-extended subtraction is the borrow out.
  logic [N:0] diff;
  assign diff = {1'b0, a} - {1'b0, b};
  assign lt_u = diff[N];
`else
  // Without unsigned compares the borrow is never needed, so the
  // subtractor is only N bits wide.
  logic [N-1:0] diff;
  assign diff = a - b;
  assign lt_u = 1'b0;
`endif

  logic ovf;

  // Signed overflow: operands differ in sign and the result sign differs
  // from a. The raw sign bit alone is wrong when the subtraction overflows.
  assign ovf  = (a[N-1] ^ b[N-1]) & (diff[N-1] ^ a[N-1]);
  assign lt_s = diff[N-1] ^ ovf;
  assign eq   = (diff[N-1:0] == '0);

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: captures one branch request, evaluates its
// condition and returns the taken flag and resolved fetch address through
// a valid/ready handshake. Three-state FSM: IDLE (accept), CMP (evaluate),
// DONE (hold result until consumed).
// Ports:
//   clk, rstn           : clock, synchronous active-low reset
//   in_valid, in_ready  : request handshake
//   op, a, b, pc, imm   : condition code, operands, branch PC, byte offset
//   out_valid, out_ready: result handshake
//   taken, next_pc      : resolved condition and fetch address
//   illegal             : op not supported (result is pc+4, not taken)
// Optional feature macro: BRANCH_UNIT_UNSIGNED_EN (enables BLTU/BGEU).
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [N-1:0] next_pc,
  output logic         illegal
);

  // Returns {illegal, taken} for a condition code and comparator flags.
  function automatic logic [1:0] resolve(input logic [2:0] code,
                                         input logic eq, input logic lt_s,
                                         input logic lt_u);
    logic [1:0] r;
    r = 2'b10;
    case (code)
      OP_BEQ:  r = {1'b0, eq};
      OP_BNE:  r = {1'b0, ~eq};
      OP_BLT:  r = {1'b0, lt_s};
      OP_BGE:  r = {1'b0, ~lt_s};
`ifdef BRANCH_UNIT_UNSIGNED_EN
      OP_BLTU: r = {1'b0, lt_u};
      OP_BGEU: r = {1'b0, ~lt_u};
`endif
      default: r = 2'b10;
    endcase
`ifndef BRANCH_UNIT_UNSIGNED_EN
    r = r | {1'b0, lt_u & 1'b0};
`endif
    return r;
  endfunction

  state_t state, state_nx;
  logic   capture, compute;

  logic [2:0]   op_p0;
  logic [N-1:0] a_p0, b_p0, pc_p0, imm_p0;

  logic         taken_p1, illegal_p1;
  logic [N-1:0] next_pc_p1;

  logic         cmp_eq, cmp_lt_s, cmp_lt_u;
  logic [1:0]   res;
  logic [N-1:0] pc_res;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    compute   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low during reset so nothing is offered before release.
        in_ready = rstn;
        if (in_valid && rstn) begin
          capture  = 1'b1;
          state_nx = ST_CMP;
        end
      end
      ST_CMP: begin
        compute  = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---- stage p0: request capture (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (capture) begin
      op_p0  <= op;
      a_p0   <= a;
      b_p0   <= b;
      pc_p0  <= pc;
      imm_p0 <= imm;
    end
  end

  branch_cmp #(.N(N)) u_cmp (
    .a    (a_p0),
    .b    (b_p0),
    .eq   (cmp_eq),
    .lt_s (cmp_lt_s),
    .lt_u (cmp_lt_u)
  );

  assign res    = resolve(op_p0, cmp_eq, cmp_lt_s, cmp_lt_u);
  assign pc_res = res[0] ? (pc_p0 + imm_p0) : (pc_p0 + N'(PC_INC));

  // ---- stage p1: resolved result, held stable through DONE ----
  // Visible outputs are cleared on reset so a discarded request leaves
  // nothing behind.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      taken_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
      next_pc_p1 <= '0;
    end else if (compute) begin
      taken_p1   <= res[0];
      illegal_p1 <= res[1];
      next_pc_p1 <= pc_res;
    end
  end

  assign taken   = taken_p1;
  assign illegal = illegal_p1;
  assign next_pc = next_pc_p1;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (N=32). Expected values are
// hand-computed; BLTU/BGEU expectations follow BRANCH_UNIT_UNSIGNED_EN.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b, pc, imm;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] next_pc;
  logic        illegal;

  int checks = 0;
  int errors = 0;

`ifdef BRANCH_UNIT_UNSIGNED_EN
  localparam bit UNS = 1'b1;
`else
  localparam bit UNS = 1'b0;
`endif

  branch_unit #(.N(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .pc        (pc),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .next_pc   (next_pc),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, check latency, hold for 'hold' cycles
  // with out_ready low (injecting a competing request), then consume.
  task automatic do_req(input string tag, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] pcv, input logic [31:0] immv,
                        input int hold, input logic exp_t,
                        input logic [31:0] exp_pc, input logic exp_ill);
    op = o; a = av; b = bv; pc = pcv; imm = immv;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    step();                                   // accept edge t
    in_valid = 1'b0;
    chk({tag, "_cmp_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_cmp_in_ready"}, 32'(in_ready), 32'd0);
    step();                                   // edge t+1 -> DONE
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_taken"}, 32'(taken), 32'(exp_t));
    chk({tag, "_next_pc"}, next_pc, exp_pc);
    chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      // Competing request while busy must be ignored.
      in_valid = 1'b1; op = 3'b001; a = 32'd9; b = 32'd9;
      pc = 32'h0000_0800; imm = 32'h0000_0040;
      step();
      chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_taken"}, 32'(taken), 32'(exp_t));
      chk({tag, "_hold_next_pc"}, next_pc, exp_pc);
    end
    out_ready = 1'b1;
    step();                                   // consume
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_after_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_after_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'b000; a = '0; b = '0; pc = '0; imm = '0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    do_req("blt_ovf", 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h100,
           32'h20, 0, 1'b1, 32'h120, 1'b0);
    do_req("bltu", 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'h100,
           32'h20, 0, 1'b0, 32'h104, !UNS);
    do_req("beq_hold", 3'b000, 32'd5, 32'd5, 32'h40, 32'hFFFF_FFF0, 3,
           1'b1, 32'h30, 1'b0);
    // The request injected during the hold must not surface.
    step();
    step();
    chk("beq_hold_no_ghost", 32'(out_valid), 32'd0);
    do_req("bne_wrap", 3'b001, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 0,
           1'b1, 32'h4, 1'b0);
    do_req("op010", 3'b010, 32'd1, 32'd1, 32'h200, 32'h40, 0,
           1'b0, 32'h204, 1'b1);
    do_req("op011", 3'b011, 32'd3, 32'd7, 32'h300, 32'h40, 1,
           1'b0, 32'h304, 1'b1);
    do_req("bge_ovf", 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 32'h10,
           32'h100, 0, 1'b1, 32'h110, 1'b0);
    do_req("bgeu", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h10,
           32'h100, 0, 1'b0, 32'h14, !UNS);
    do_req("bgeu_eq", 3'b111, 32'd6, 32'd6, 32'h20, 32'h8, 0,
           UNS, UNS ? 32'h28 : 32'h24, !UNS);
    do_req("beq_ne", 3'b000, 32'd3, 32'd4, 32'h0, 32'h80, 0,
           1'b0, 32'h4, 1'b0);
    do_req("blt_neg", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h1000,
           32'hFFFF_FF00, 0, 1'b1, 32'h0F00, 1'b0);
    do_req("bge_lt", 3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h50,
           32'h10, 0, 1'b0, 32'h54, 1'b0);

    // Reset while in CMP discards the request.
    op = 3'b000; a = 32'd7; b = 32'd7; pc = 32'h500; imm = 32'h10;
    in_valid = 1'b1;
    step();                                   // accepted, now in CMP
    in_valid = 1'b0;
    rstn = 1'b0;
    step();
    chk("rcmp_out_valid", 32'(out_valid), 32'd0);
    chk("rcmp_taken", 32'(taken), 32'd0);
    chk("rcmp_next_pc", next_pc, 32'd0);
    chk("rcmp_illegal", 32'(illegal), 32'd0);
    chk("rcmp_in_ready_low", 32'(in_ready), 32'd0);
    rstn = 1'b1;
    #1;
    chk("rcmp_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rcmp_no_ghost", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
